// File: rtl/gray_counter_n.sv
// Gray-code up/down counter with sticky overflow and one-cycle wrap pulse.
// Down counting is compiled in only when GRAY_DOWN_COUNT_EN is defined.
module gray_counter_n #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] BinOut,
  output logic             Overflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] cnt_nxt;
  logic             cnt_wrap;
  logic             ovf;
  logic             wrap;

  // Gray-to-binary of the load value: prefix XOR from the MSB down
  always_comb begin
    load_bin = '0;
    load_bin[WIDTH-1] = LoadVal[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      load_bin[i] = load_bin[i+1] ^ LoadVal[i];
    end
  end

`ifdef GRAY_DOWN_COUNT_EN
  // Next count and wrap detect in the sampled direction
  always_comb begin
    cnt_nxt  = b + 1'b1;
    cnt_wrap = (b == MAX);
    if (Dir) begin
      cnt_nxt  = b - 1'b1;
      cnt_wrap = (b == '0);
    end
  end
`else
  logic unused_dir;
  assign unused_dir = Dir;

  // Up-only next count and wrap detect
  always_comb begin
    cnt_nxt  = b + 1'b1;
    cnt_wrap = (b == MAX);
  end
`endif

  // State update: reset beats load beats count; load never wraps
  always_ff @(posedge Clk) begin
    if (Reset) begin
      b    <= '0;
      ovf  <= 1'b0;
      wrap <= 1'b0;
    end else if (Load) begin
      b    <= load_bin;
      wrap <= 1'b0;
    end else if (En) begin
      b    <= cnt_nxt;
      wrap <= cnt_wrap;
      ovf  <= ovf | cnt_wrap;
    end else begin
      wrap <= 1'b0;
    end
  end

  assign Output   = b ^ (b >> 1);
  assign BinOut   = b;
  assign Overflow = ovf;
  assign Wrap     = wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n at WIDTH=3.
// Honours GRAY_DOWN_COUNT_EN the same way the design does.
module tb_gray_counter_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic       ld;
  logic [2:0] lv;
  logic [2:0] gout;
  logic [2:0] bout;
  logic       ovf;
  logic       wrp;

  typedef struct {
    logic [2:0] g;
    logic [2:0] b;
    logic       o;
    logic       w;
  } exp_t;

  exp_t sb[$];

  int n_vec;
  int n_err;

  int mb;
  logic movf;
  logic mwrap;

  logic [2:0] gtab [8];

  gray_counter_n #(.WIDTH(3)) dut (
    .Clk(clk),
    .Reset(rst),
    .En(en),
    .Dir(dir),
    .Load(ld),
    .LoadVal(lv),
    .Output(gout),
    .BinOut(bout),
    .Overflow(ovf),
    .Wrap(wrp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic int g2i(input logic [2:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++)
      if (gtab[i] == g) r = i;
    return r;
  endfunction

  task automatic step(input logic r, input logic e,
                      input logic d, input logic l,
                      input logic [2:0] v);
    exp_t x;
    logic w;
    @(negedge clk);
    rst = r; en = e; dir = d; ld = l; lv = v;
    if (r) begin
      mb = 0; movf = 1'b0; mwrap = 1'b0;
    end else if (l) begin
      mb = g2i(v); mwrap = 1'b0;
    end else if (e) begin
`ifdef GRAY_DOWN_COUNT_EN
      if (d) begin
        w = (mb == 0);
        mb = (mb + 7) % 8;
      end else begin
        w = (mb == 7);
        mb = (mb + 1) % 8;
      end
`else
      w = (mb == 7);
      mb = (mb + 1) % 8;
`endif
      mwrap = w;
      movf = movf | w;
    end else begin
      mwrap = 1'b0;
    end
    x.g = gtab[mb];
    x.b = 3'(mb);
    x.o = movf;
    x.w = mwrap;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("gray", 32'(gout), 32'(x.g));
    check("bin", 32'(bout), 32'(x.b));
    check("ovf", 32'(ovf), 32'(x.o));
    check("wrap", 32'(wrp), 32'(x.w));
  endtask

  initial begin
    gtab[0] = 3'b000; gtab[1] = 3'b001;
    gtab[2] = 3'b011; gtab[3] = 3'b010;
    gtab[4] = 3'b110; gtab[5] = 3'b111;
    gtab[6] = 3'b101; gtab[7] = 3'b100;
    n_vec = 0; n_err = 0;
    mb = 0; movf = 1'b0; mwrap = 1'b0;
    rst = 1'b1; en = 1'b0; dir = 1'b0;
    ld = 1'b0; lv = 3'b000;

    // reset, then 8 up counts through the wrap
    step(1, 0, 0, 0, 3'b000);
    check("rst_gray", 32'(gout), 32'h0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 3'b000);
    check("up8_gray", 32'(gout), 32'h0);
    check("up8_wrap", 32'(wrp), 32'h1);
    check("up8_ovf", 32'(ovf), 32'h1);

    // sticky overflow, then reset with En held
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 3'b000);
    check("stick_ovf", 32'(ovf), 32'h1);
    step(1, 1, 0, 1, 3'b101);
    check("rst2_ovf", 32'(ovf), 32'h0);

    // count to 111, load 100 over En, then wrap
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 3'b000);
    check("at111", 32'(gout), 32'h7);
    step(0, 1, 0, 1, 3'b100);
    check("ld_bin", 32'(bout), 32'h7);
    step(0, 1, 0, 0, 3'b000);
    check("ldwrap", 32'(wrp), 32'h1);

    // load at would-be wrap suppresses it
    step(0, 0, 0, 1, 3'b100);
    step(0, 1, 0, 1, 3'b010);
    check("ld_sup_g", 32'(gout), 32'h2);
    check("ld_sup_w", 32'(wrp), 32'h0);

    // hold at 110
    step(0, 0, 0, 1, 3'b110);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 3'b000);
    check("hold", 32'(gout), 32'h6);

    // first count after reset with Dir=1
    step(1, 0, 0, 0, 3'b000);
    step(0, 1, 1, 0, 3'b000);
`ifdef GRAY_DOWN_COUNT_EN
    check("dn_g", 32'(gout), 32'h4);
    check("dn_w", 32'(wrp), 32'h1);
    step(0, 1, 1, 0, 3'b000);
    check("dn_g2", 32'(gout), 32'h5);
`else
    check("dn_g", 32'(gout), 32'h1);
    check("dn_w", 32'(wrp), 32'h0);
`endif

    // random mix
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 19) == 0,
           1'($urandom), 1'($urandom),
           $urandom_range(0, 5) == 0,
           3'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
